// File: rtl/sm3_pkg.sv
// SM3 constants, round helper functions and the compression-core FSM encoding.
package sm3_pkg;

    localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LO   = 32'h79cc4519;
    localparam logic [31:0]  T_HI   = 32'h7a879d8a;
    localparam int           ROUNDS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINISH,
        ST_DONE
    } cf_state_e;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
    endfunction

    function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
    endfunction

    function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic hi);
        return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
    endfunction

    // W(j+16) from window words W(j), W(j+3), W(j+7), W(j+10), W(j+13).
    function automatic logic [31:0] expand(input logic [31:0] w0, input logic [31:0] w3,
                                           input logic [31:0] w7, input logic [31:0] w10,
                                           input logic [31:0] w13);
        return p1(w0 ^ w7 ^ rotl32(w13, 5'd15)) ^ rotl32(w3, 5'd7) ^ w10;
    endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round; state words packed A (MSB) .. H (LSB).
module sm3_round
    import sm3_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_w,
    input  logic [31:0]  i_wp,
    input  logic [5:0]   i_j,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic        w_hi;
    logic [31:0] w_t, w_a12, w_ss1, w_ss2, w_tt1, w_tt2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_hi  = (i_j[5:4] != 2'b00);
    assign w_t   = w_hi ? T_HI : T_LO;
    assign w_a12 = rotl32(w_a, 5'd12);
    // Tj rotation amount is j mod 32, i.e. the low five bits of j.
    assign w_ss1 = rotl32(w_a12 + w_e + rotl32(w_t, i_j[4:0]), 5'd7);
    assign w_ss2 = w_ss1 ^ w_a12;
    assign w_tt1 = ff_j(w_a, w_b, w_c, w_hi) + w_d + w_ss2 + i_wp;
    assign w_tt2 = gg_j(w_e, w_f, w_g, w_hi) + w_h + w_ss1 + i_w;

    assign o_state = {w_tt1, w_a, rotl32(w_b, 5'd9), w_c,
                      p0(w_tt2), w_e, rotl32(w_f, 5'd19), w_g};

endmodule

// File: rtl/sm3_cf_core.sv
// Iterative SM3 compression core behind the cf_start/cf_end handshake.
// Define SM3_CF_TWO_ROUND_EN to run two chained rounds per cycle.
module sm3_cf_core
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cf_start,
    input  logic [255:0] iv,
    input  logic [511:0] block,
    output logic [255:0] hash_out,
    output logic         cf_end,
    output logic         cf_busy
);

`ifdef SM3_CF_TWO_ROUND_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [5:0] LAST = 6'(ROUNDS / STEP - 1);

    cf_state_e         r_state, w_state_nxt;
    logic [255:0]      r_v, r_st, r_hash;
    logic [15:0][31:0] r_w;
    logic [5:0]        r_j;
    logic              r_end;
    logic              w_busy;
    logic [255:0]      w_st0, w_nxt;
    logic [15:0][31:0] w_w_nxt;
    logic [5:0]        w_j0;

`ifdef SM3_CF_TWO_ROUND_EN
    logic [255:0] w_st1;
    logic [5:0]   w_j1;

    assign w_j0 = {r_j[4:0], 1'b0};
    assign w_j1 = {r_j[4:0], 1'b1};

    sm3_round u_rnd0 (.i_state(r_st),  .i_w(r_w[0]), .i_wp(r_w[0] ^ r_w[4]), .i_j(w_j0), .o_state(w_st0));
    sm3_round u_rnd1 (.i_state(w_st0), .i_w(r_w[1]), .i_wp(r_w[1] ^ r_w[5]), .i_j(w_j1), .o_state(w_st1));

    assign w_nxt   = w_st1;
    // Both new words depend only on the current window, so they are computed side by side.
    assign w_w_nxt = {expand(r_w[1], r_w[4], r_w[8], r_w[11], r_w[14]),
                      expand(r_w[0], r_w[3], r_w[7], r_w[10], r_w[13]),
                      r_w[15:2]};
`else
    assign w_j0 = r_j;

    sm3_round u_rnd0 (.i_state(r_st), .i_w(r_w[0]), .i_wp(r_w[0] ^ r_w[4]), .i_j(w_j0), .o_state(w_st0));

    assign w_nxt   = w_st0;
    assign w_w_nxt = {expand(r_w[0], r_w[3], r_w[7], r_w[10], r_w[13]), r_w[15:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cf_start) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_ROUND;
            ST_ROUND:  if (r_j == LAST) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_DONE;
            ST_DONE:   if (!cf_start) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_LOAD, ST_ROUND, ST_FINISH: w_busy = 1'b1;
            default:                      w_busy = 1'b0;
        endcase
    end

    // The LOAD cycle already carries the first round so rounds land on edges 1..64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v    <= '0;
            r_st   <= '0;
            r_w    <= '0;
            r_j    <= '0;
            r_hash <= '0;
            r_end  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cf_start) begin
                        r_v  <= iv;
                        r_st <= iv;
                        r_j  <= '0;
                        for (int k = 0; k < 16; k++) r_w[k] <= block[511 - 32*k -: 32];
                    end
                end
                ST_LOAD, ST_ROUND: begin
                    r_st <= w_nxt;
                    r_w  <= w_w_nxt;
                    r_j  <= r_j + 6'd1;
                end
                ST_FINISH: begin
                    r_hash <= r_v ^ r_st;
                    r_end  <= 1'b1;
                end
                ST_DONE: if (!cf_start) r_end <= 1'b0;
                default: ;
            endcase
        end
    end

    assign hash_out = r_hash;
    assign cf_end   = r_end;
    assign cf_busy  = w_busy;

endmodule

// File: doc/sm3_cf_core.md
# sm3_cf_core

Iterative SM3 compression-function core: the responder side of the `cf_start`/`cf_end` handshake used by the hash wrappers in the Picnic-on-SM4 datapath. On each accepted request it compresses one 512-bit message block into a 256-bit chaining value, V(i+1) = CF(V(i), B(i)). It executes one round per cycle and holds the result for the initiator. Padding and multi-block sequencing stay in the wrappers.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cf_start` in 1: request level; initiator holds it high until it sees `cf_end`.
- `iv` in 256: chaining value V; word A = `iv[255:224]` … word H = `iv[31:0]`.
- `block` in 512: message block B; W0 = `block[511:480]` … W15 = `block[31:0]` (big-endian words).
- `hash_out` out 256: V ^ ABCDEFGH, same word order as `iv`.
- `cf_end` out 1: result valid, level.
- `cf_busy` out 1: high in LOAD/ROUND/FINISH.

## Operation
- **States and transitions:**
  - IDLE → LOAD when `cf_start`=1. In this cycle: capture `iv` into V and into A..H; capture `block` into the 16-word W window; clear the round counter j.
  - LOAD → ROUND.
  - ROUND (j=0..63) → FINISH after j=63.
  - FINISH → DONE. In this cycle: `hash_out` <= V ^ {A..H}; `cf_end` <= 1.
  - DONE → IDLE when `cf_start`=0. In this cycle: `cf_end` <= 0.
- **Re-arm rule:** a new job needs `cf_start` to be seen low in DONE. A level still held high at DONE never re-triggers.
- **Round j:**
  - SS1 = ((A<<<12) + E + (Tj<<<(j mod 32)))<<<7; SS2 = SS1 ^ (A<<<12).
  - TT1 = FFj(A,B,C) + D + SS2 + W'j; TT2 = GGj(E,F,G) + H + SS1 + Wj.
  - D=C, C=B<<<9, B=A, A=TT1; H=G, G=F<<<19, F=E, E=P0(TT2).
  - All additions are mod 2^32 (32-bit truncating).
  - Tj = 79cc4519 for j<16, 7a879d8a otherwise.
  - FF/GG are XOR for j<16, majority/choose otherwise.
- **Message expansion** runs on the fly from the 16-word sliding window:
  - Wj = window[0]; W'j = window[0] ^ window[4].
  - Shift in W(j+16) = P1(W(j)^W(j+7)^(W(j+13)<<<15)) ^ (W(j+3)<<<7) ^ W(j+10).
- **Inputs:** `iv`/`block` are sampled only at IDLE→LOAD. Later changes are ignored.
- **Output hold:** `hash_out` holds its value until the next FINISH overwrites it, including through IDLE. The initiator reads it both at `cf_end` and later.
- **Reset:** all outputs go to 0 at any time. An in-flight job is aborted and the FSM returns to IDLE.

## Timing
- Edge 0: `cf_start` is sampled high in IDLE (capture).
- Edges 1..64: rounds j=0..63.
- Edge 65: `hash_out` and `cf_end` are registered.
- `cf_end` is first high in the cycle after edge 65, i.e. 65 cycles after capture.
- `cf_busy` is high from edge 0 until edge 65.
- `cf_end` falls on the first edge where `cf_start`=0 in DONE.
- The earliest next capture is the edge after that, so back-to-back jobs cost 67 cycles at best.

## Configuration
- **`SM3_CF_TWO_ROUND_EN` defined:** two chained rounds per ROUND cycle (j, j+1); the window shifts by two words.
  - Counter runs 0..31; `cf_end` is first high 33 cycles after capture.
- **Undefined:** one round per cycle, 65-cycle latency.
- Handshake, re-arm and reset behaviour are identical in both builds.

## Structure
- **Package `sm3_pkg`:**
  - SM3 standard IV constant (7380166f…b0fb0e4e).
  - T_LO/T_HI constants and the round count 64.
  - Functions P0, P1, FFj, GGj, rotl32.
  - FSM state enum.
- **Sub-module `sm3_round`:** combinational; inputs A..H, Wj, W'j, j; outputs next A..H.
  - Instantiated once, or twice under `SM3_CF_TWO_ROUND_EN`.

## Test plan
- **"abc":** `iv`=standard IV, `block`=61626380 followed by 13 zero words then 00000018 → `hash_out`=66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0. `cf_end` rises exactly 65 cycles after capture (33 with the macro).
- **Two-block "abcd"×16** (message block, then padding block 80000000…00000200), chaining `hash_out` into `iv`. Final result = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- **Held `cf_start`:** keep `cf_start` high 20 cycles past `cf_end` → no second job starts. Release it → `cf_end` falls next edge, `hash_out` unchanged.
- **Input stability:** randomize `iv`/`block` every cycle after capture → result still matches the "abc" vector.
- **Reset mid-job:** assert `reset` at round 30 → `hash_out`=0, `cf_end`=0, `cf_busy`=0 immediately. A fresh "abc" job afterwards gives the correct digest.
- **Reset in DONE:** assert `reset` while in DONE → `cf_end` and `hash_out` clear asynchronously. A new request is accepted on the first edge after reset releases.
